// File: rtl/loader_pkg.sv
// Shared definitions for the manual programming path.
// FSM state encoding plus default geometry of the instruction memory.
package loader_pkg;

    typedef enum logic [1:0] {
        HI   = 2'd0,
        LO   = 2'd1,
        FULL = 2'd2
    } loader_state_t;

    localparam int LOADER_ADDR_W = 6;
    localparam int LOADER_DEPTH  = 1 << LOADER_ADDR_W;

endpackage

// File: rtl/debouncer.sv
// Button conditioning: 2-flop synchronizer, stable-count debouncer and
// rising-edge detector.
// Ports: clk, reset (sync, active-high), button (raw async), press (1-cycle).
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          btn_s;
    logic          db;
    logic          db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
            db    <= 1'b0;
            db_q  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= button;
            btn_s <= sync1;
            db_q  <= db;
            // Any sample matching the accepted level restarts the count,
            // so only an unbroken run of differing samples is accepted.
            if (btn_s == db) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                db  <= btn_s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = db & ~db_q;

endmodule

// File: rtl/program_loader.sv
// Assembles pairs of switch bytes into 16-bit instruction memory writes.
// Ports: clk, reset, button, instruction[7:0] -> wr_en, wr_addr, wr_data,
//        hi_pending, full, word_count.
module program_loader
    import loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ADDR_W          = LOADER_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button,
    input  logic [7:0]        instruction,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              hi_pending,
    output logic              full,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic press;

    loader_state_t     state;
    loader_state_t     state_n;
    logic [7:0]        hi_reg;
    logic [7:0]        hi_n;
    logic              wr_en_n;
    logic [ADDR_W-1:0] addr_n;
    logic [15:0]       data_n;
    logic [ADDR_W:0]   count_n;

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk   (clk),
        .reset (reset),
        .button(button),
        .press (press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HI;
            hi_reg     <= 8'd0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 16'd0;
            word_count <= '0;
        end else begin
            state      <= state_n;
            hi_reg     <= hi_n;
            wr_en      <= wr_en_n;
            wr_addr    <= addr_n;
            wr_data    <= data_n;
            word_count <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        hi_n    = hi_reg;
        wr_en_n = 1'b0;
        addr_n  = wr_addr;
        data_n  = wr_data;
        count_n = word_count;
        unique case (1'b1)
            (state == HI): begin
                if (press) begin
                    hi_n    = instruction;
                    state_n = LO;
                end
            end
            (state == LO): begin
                if (press) begin
                    data_n  = {hi_reg, instruction};
                    addr_n  = word_count[ADDR_W-1:0];
                    wr_en_n = 1'b1;
                    count_n = word_count + 1'b1;
                    state_n = (count_n == DEPTH) ? FULL : HI;
                end
            end
            (state == FULL): begin
                state_n = FULL;
            end
            default: begin
                state_n = HI;
            end
        endcase
    end

    assign hi_pending = (state == LO);
    assign full       = (state == FULL);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader (DEBOUNCE_CYCLES=4, ADDR_W=6).
module tb_program_loader;
    import loader_pkg::*;

    localparam int D = 4;
    localparam int AW = LOADER_ADDR_W;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } exp_t;

    typedef struct {
        logic [7:0] sw;
        logic       exp_hi;
        logic [6:0] exp_cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          button = 1'b0;
    logic [7:0]    instruction = 8'd0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          hi_pending;
    logic          full;
    logic [AW:0]   word_count;

    int   checks = 0;
    int   fails = 0;
    int   writes = 0;
    logic prev_wr = 1'b0;
    exp_t sb[$];
    exp_t got;
    vec_t vecs[4];

    program_loader #(
        .DEBOUNCE_CYCLES(D),
        .ADDR_W(AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .button     (button),
        .instruction(instruction),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .hi_pending (hi_pending),
        .full       (full),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            writes++;
            check("wr_en_width", 32'(prev_wr), 32'd0);
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h expected none",
                         wr_addr, wr_data);
            end else begin
                got = sb.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(got.addr));
                check("wr_data", 32'(wr_data), 32'(got.data));
            end
        end
        prev_wr = wr_en;
    end

    task automatic push(input int addr, input logic [15:0] data);
        exp_t e;
        e.addr = AW'(addr);
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic press(input logic [7:0] sw, input int hold);
        @(negedge clk);
        instruction = sw;
        button = 1'b1;
        repeat (hold) @(negedge clk);
        button = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_hi_pending", 32'(hi_pending), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int len;
        int t;
        int w0;

        vecs[0] = '{sw: 8'h41, exp_hi: 1'b1, exp_cnt: 7'd0};
        vecs[1] = '{sw: 8'h03, exp_hi: 1'b0, exp_cnt: 7'd1};
        vecs[2] = '{sw: 8'hC5, exp_hi: 1'b1, exp_cnt: 7'd1};
        vecs[3] = '{sw: 8'h7E, exp_hi: 1'b0, exp_cnt: 7'd2};

        do_reset();

        for (int i = 0; i < 4; i++) begin
            if (!vecs[i].exp_hi)
                push(int'(vecs[i].exp_cnt) - 1, {vecs[i-1].sw, vecs[i].sw});
            press(vecs[i].sw, D + 6);
            check("tbl_hi_pending", 32'(hi_pending), 32'(vecs[i].exp_hi));
            check("tbl_word_count", 32'(word_count), 32'(vecs[i].exp_cnt));
        end

        // Latency of the low-byte press: write visible in cycle D+3.
        press(8'h10, D + 6);
        push(2, 16'h1020);
        @(negedge clk);
        instruction = 8'h20;
        button = 1'b1;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (wr_en) begin
                n = k;
                break;
            end
        end
        check("wr_latency", 32'(n), 32'(D + 3));
        check("lat_word_count", 32'(word_count), 32'd3);
        repeat (4) @(negedge clk);
        button = 1'b0;
        repeat (D + 6) @(negedge clk);

        // Bouncing button, then a steady hold: one capture only.
        instruction = 8'h5A;
        t = 0;
        while (t < 20) begin
            len = $urandom_range(1, 2);
            button = ~button;
            repeat (len) @(negedge clk);
            t += len;
        end
        check("bounce_no_press", 32'(hi_pending), 32'd0);
        button = 1'b1;
        repeat (D + 6) @(negedge clk);
        button = 1'b0;
        repeat (D + 6) @(negedge clk);
        check("bounce_hi_pending", 32'(hi_pending), 32'd1);

        // 3-cycle pulse is too short to be accepted.
        @(negedge clk);
        instruction = 8'hEE;
        button = 1'b1;
        repeat (3) @(negedge clk);
        button = 1'b0;
        repeat (D + 6) @(negedge clk);
        check("short_hi_pending", 32'(hi_pending), 32'd1);
        check("short_word_count", 32'(word_count), 32'd3);
        push(3, 16'h5A66);
        press(8'h66, D + 6);

        // Long hold: one capture.
        press(8'h11, 100);
        check("hold_hi_pending", 32'(hi_pending), 32'd1);
        push(4, 16'h1122);
        press(8'h22, D + 6);
        check("hold_word_count", 32'(word_count), 32'd5);

        // Reset while LO drops the captured high byte.
        press(8'hAA, D + 6);
        check("aa_hi_pending", 32'(hi_pending), 32'd1);
        do_reset();
        press(8'h12, D + 6);
        push(0, 16'h1234);
        press(8'h34, D + 6);
        check("rstlo_word_count", 32'(word_count), 32'd1);

        // Fill the whole memory.
        do_reset();
        w0 = writes;
        for (int i = 0; i < 2 * LOADER_DEPTH; i++) begin
            if (i % 2 == 1)
                push(i / 2, {8'(i - 1), 8'(i)});
            press(8'(i), D + 6);
        end
        check("fill_writes", 32'(writes - w0), 32'(LOADER_DEPTH));
        check("fill_full", 32'(full), 32'd1);
        check("fill_word_count", 32'(word_count), 32'(LOADER_DEPTH));
        check("fill_hi_pending", 32'(hi_pending), 32'd0);
        press(8'hFF, D + 6);
        check("extra_writes", 32'(writes - w0), 32'(LOADER_DEPTH));
        check("extra_full", 32'(full), 32'd1);
        check("extra_word_count", 32'(word_count), 32'(LOADER_DEPTH));

        // Reset out of FULL.
        do_reset();
        press(8'hBE, D + 6);
        push(0, 16'hBEEF);
        press(8'hEF, D + 6);
        check("post_full_count", 32'(word_count), 32'd1);
        check("post_full_full", 32'(full), 32'd0);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Front end of the manual programming path: turns the raw push-button and 8-bit switch bank into clean, single-cycle 16-bit write transactions for the 64-word instruction memory. Each press captures one byte, high byte first; every second press emits one write. The memory therefore sees a plain synchronous write port (`wr_en`/`wr_addr`/`wr_data`) and never samples the button directly.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000. Consecutive stable cycles required before a button level change is accepted. Must be ≥ 2.
- `ADDR_W`, default 6. Word-address width; depth = 2^ADDR_W.
- `clk`  in  1  system clock. One clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `button`  in  1  raw, asynchronous, bouncing push-button.
- `instruction`  in  8  switch bank; sampled only on an accepted press.
- `wr_en`  out  1  one-cycle write strobe to instruction memory.
- `wr_addr`  out  ADDR_W  word address for the write.
- `wr_data`  out  16  `{high_byte, low_byte}`.
- `hi_pending`  out  1  high byte captured; low byte awaited.
- `full`  out  1  all 2^ADDR_W words written; further presses are ignored.
- `word_count`  out  ADDR_W+1  number of words written so far.

## Operation
- Button path:
  - 2-flop synchronizer gives `btn_s`.
  - Debouncer holds level `db` (reset 0) and counter `cnt` (reset 0).
  - If `btn_s == db`, `cnt` is cleared to 0.
  - Otherwise `cnt` increments. When `cnt == DEBOUNCE_CYCLES-1` with `btn_s != db`, `db` takes `btn_s` and `cnt` clears.
  - `press` = rising edge of `db` (one cycle). Falling edges produce nothing.
- FSM states:
  - `HI` (reset state): on `press`, latch `instruction` into `hi_reg` and go to `LO`.
  - `LO`: on `press`, register `wr_data = {hi_reg, instruction}` and `wr_addr = word_count[ADDR_W-1:0]`, and pulse `wr_en` for the next cycle. Then `word_count` increments. Go to `FULL` if the new count equals 2^ADDR_W, else `HI`.
  - `FULL`: absorbing state. `press` is ignored and `wr_en` is never asserted. Only `reset` leaves it.
- Outputs: `hi_pending` = (state == `LO`); `full` = (state == `FULL`).
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `hi_pending`=0, `full`=0, `word_count`=0. `hi_reg`=0, `db`=0, `cnt`=0, synchronizer flops 0.
- Reset during `LO` discards the captured high byte. Writes already issued are not undone; memory contents are not this block's concern.
- `instruction` changes outside a `press` cycle have no effect.

## Timing
- Latency, defined from the first rising `clk` edge at which `button` is sampled high and then held high without bounce:
  - `press` is high in cycle DEBOUNCE_CYCLES+2.
  - The FSM state and `hi_reg` update at the end of that cycle.
  - For a low-byte press, `wr_en`/`wr_addr`/`wr_data` are valid in cycle DEBOUNCE_CYCLES+3.
- `word_count` updates in the same edge that raises `wr_en`.
- `wr_en` is exactly 1 cycle wide, and at most 1 write per 2 accepted presses.
- Glitches shorter than DEBOUNCE_CYCLES cycles on `btn_s` produce no `press`.
- Holding the button indefinitely yields exactly one `press`.
- Back-to-back presses need a release of ≥ DEBOUNCE_CYCLES stable-low cycles between them.
- `reset` asserted in the same cycle as `press`: reset wins, and the press is lost.

## Structure
- Shared package (`loader_pkg`):
  - FSM state encoding `HI`=2'd0, `LO`=2'd1, `FULL`=2'd2.
  - Default `ADDR_W` and depth constant.
- Sub-module `debouncer`:
  - Contains the synchronizer, `cnt`, `db` and the rising-edge `press` output.
  - Parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `button`, `press`.
- The top level holds the FSM, `hi_reg`, the output registers and `word_count`.

## Test plan
(Benches run with `DEBOUNCE_CYCLES`=4, `ADDR_W`=6 unless stated.)
- Two clean presses, switches 0x41 then 0x03 → one `wr_en` pulse, `wr_addr`=0, `wr_data`=0x4103, `word_count`=1, `hi_pending` 1 between presses and 0 after. Second `wr_en` appears exactly 7 cycles after the press's first high sample.
- Bounce: `button` toggles 1-2-cycle pulses for 20 cycles, then holds high → exactly one `press`, and `hi_pending`=1, `hi_reg` = switches at that cycle. A 3-cycle pulse alone → no state change.
- Button held 100 cycles, then released → single capture only.
- 128 presses with switch values `i` → 64 writes with `wr_data={2i,2i+1}` at addresses 0..63, `full`=1, `word_count`=64. A 129th press → no `wr_en`, state unchanged.
- Press high byte 0xAA, `reset`, then press 0x12 and 0x34 → single write `wr_addr`=0, `wr_data`=0x1234.
- Reset mid-`FULL` → all outputs return to reset values, and the next two presses write address 0.
